// File: rtl/alu_mdu.sv
// EX-stage ALU-control decoder with an iterative multiply/divide unit and HI/LO registers.
// Mult/div runs in the background. Only a later MDU instruction is stalled while the unit is busy.
module alu_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [2:0]       alu_ctrl,
    output logic [WIDTH-1:0] mf_result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             done
);

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam int         CW      = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

    state_t            state, state_next;
    logic [CW-1:0]     cnt;
    logic              last_iter;
    logic              mdu_funct, start_op, mdu_req, issue, start, mt_hi, mt_lo;
    logic              op_signed, sa, sb;
    logic [WIDTH-1:0]  mag_a, mag_b;
    logic [WIDTH-1:0]  acc, q, m, a_lat;
    logic              is_div, sign_a, sign_b, b_zero;
    logic [WIDTH:0]    mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]  fix_hi, fix_lo;

    // NOTE: every variable written in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        alu_ctrl = 3'b010;
        if (alu_op == 2'b01) begin
            alu_ctrl = 3'b110;
        end else if (alu_op[1]) begin
            case (funct)
                6'b100000: alu_ctrl = 3'b010;
                6'b100010: alu_ctrl = 3'b110;
                6'b100100: alu_ctrl = 3'b000;
                6'b100101: alu_ctrl = 3'b001;
                6'b101010: alu_ctrl = 3'b111;
                default:   alu_ctrl = 3'b010;
            endcase
        end
    end

    always_comb begin
        mdu_funct = 1'b0;
        start_op  = 1'b0;
        case (funct)
            F_MFHI, F_MTHI, F_MFLO, F_MTLO: mdu_funct = 1'b1;
            F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                mdu_funct = 1'b1;
                start_op  = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy    = (state != IDLE);
    assign mdu_req = en & alu_op[1] & mdu_funct;
    assign stall   = mdu_req & busy;
    assign issue   = mdu_req & ~busy;
    assign start   = issue & start_op;
    assign mt_hi   = issue & (funct == F_MTHI);
    assign mt_lo   = issue & (funct == F_MTLO);

    assign mf_result = (alu_op[1] && funct == F_MFHI) ? hi :
                       (alu_op[1] && funct == F_MFLO) ? lo : '0;

    // Iterations run on magnitudes. The FIX cycle restores the signs.
    assign op_signed = ~funct[0];
    assign sa        = op_signed & a[WIDTH-1];
    assign sb        = op_signed & b[WIDTH-1];
    assign mag_a     = sa ? -a : a;
    assign mag_b     = sb ? -b : b;
    assign last_iter = (cnt == CW'(WIDTH - 1));

    assign mul_sum   = {1'b0, acc} + {1'b0, (q[0] ? m : '0)};
    assign div_shift = {acc, q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, m};

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_iter) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start)              cnt <= '0;
            else if (state == RUN)  cnt <= last_iter ? '0 : cnt + 1'b1;
            if (state == FIX) begin
                hi   <= fix_hi;
                lo   <= fix_lo;
                done <= 1'b1;
            end else begin
                if (mt_hi) hi <= a;
                if (mt_lo) lo <= a;
            end
        end
    end

    // NOTE: operand/working registers carry no reset; they are only read between start and FIX,
    // and reset forces the FSM to IDLE so stale contents never reach HI/LO.
    always_ff @(posedge clk) begin
        if (start) begin
            is_div <= funct[1];
            sign_a <= sa;
            sign_b <= sb;
            b_zero <= (b == '0);
            a_lat  <= a;
            acc    <= '0;
            q      <= funct[1] ? mag_a : mag_b;
            m      <= funct[1] ? mag_b : mag_a;
        end else if (state == RUN) begin
            if (is_div) begin
                acc <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
                q   <= {q[WIDTH-2:0], ~div_diff[WIDTH]};
            end else begin
                acc <= mul_sum[WIDTH:1];
                q   <= {mul_sum[0], q[WIDTH-1:1]};
            end
        end
    end

    always_comb begin
        prod     = {acc, q};
        prod_fix = (sign_a ^ sign_b) ? -prod : prod;
        fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fix_lo   = prod_fix[WIDTH-1:0];
        if (is_div) begin
            if (b_zero) begin
                fix_hi = a_lat;
                fix_lo = '1;
            end else begin
                fix_lo = (sign_a ^ sign_b) ? -q : q;
                fix_hi = sign_a ? -acc : acc;
            end
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: decode sweep, mult/div results via a scoreboard,
// stall/busy timing, MT/MF moves, and reset in the middle of a divide.
module tb_alu_mdu;

    localparam int W = 32;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic         clk = 1'b0;
    logic         reset, en;
    logic [1:0]   alu_op;
    logic [5:0]   funct;
    logic [W-1:0] a, b;
    logic [2:0]   alu_ctrl;
    logic [W-1:0] mf_result, hi, lo;
    logic         busy, stall, done;

    int           errors = 0;
    int           checks = 0;
    logic [63:0]  sb[$];

    always #5 clk = ~clk;

    alu_mdu #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .en(en), .alu_op(alu_op), .funct(funct),
        .a(a), .b(b), .alu_ctrl(alu_ctrl), .mf_result(mf_result),
        .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ext(input logic x);
        return {{(W-1){1'b0}}, x};
    endfunction

    // Reference model: returns {hi, lo}.
    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy;
        logic [31:0] qq, rr;
        sx = $signed(x);
        sy = $signed(y);
        case (f)
            F_MULT:  return sx * sy;
            F_MULTU: return {32'd0, x} * {32'd0, y};
            F_DIV: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                qq = $signed(x) / $signed(y);
                rr = $signed(x) % $signed(y);
                return {rr, qq};
            end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    // Advance one cycle; whenever done is seen, the oldest expected result is popped and compared.
    task automatic step();
        logic [63:0] e;
        @(posedge clk);
        #1;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("done_unexpected", ext(done), '0);
            end else begin
                e = sb.pop_front();
                check("hi", hi, e[63:32]);
                check("lo", lo, e[31:0]);
            end
        end
    endtask

    task automatic drive(input logic e, input logic [1:0] op, input logic [5:0] f,
                         input logic [W-1:0] x, input logic [W-1:0] y);
        en = e; alu_op = op; funct = f; a = x; b = y;
    endtask

    task automatic dec(input logic [1:0] op, input logic [5:0] f, input logic [2:0] exp);
        step();
        drive(1'b0, op, f, '0, '0);
        #1;
        check("alu_ctrl", {{(W-3){1'b0}}, alu_ctrl}, {{(W-3){1'b0}}, exp});
    endtask

    task automatic issue(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic push, input logic [63:0] exp);
        drive(1'b1, 2'b10, f, x, y);
        #1;
        check("issue_stall", ext(stall), '0);
        if (push) sb.push_back(exp);
        step();
        en = 1'b0;
    endtask

    task automatic run_to_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            step();
            n++;
        end
    endtask

    task automatic mdu_op(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [63:0] exp);
        int n;
        issue(f, x, y, 1'b1, exp);
        run_to_idle(n);
        check("busy_len", n, 33);
        check("done_pulse", ext(done), 1);
        step();
        check("done_clear", ext(done), '0);
    endtask

    initial begin
        int n;
        logic [5:0]  f;
        logic [31:0] x, y;

        reset = 1'b1;
        drive(1'b0, 2'b10, F_MFHI, '0, '0);
        step();
        check("rst_busy", ext(busy), '0);
        check("rst_done", ext(done), '0);
        check("rst_hi", hi, '0);
        check("rst_lo", lo, '0);
        check("rst_mf", mf_result, '0);
        check("rst_stall", ext(stall), '0);
        reset = 1'b0;

        dec(2'b00, F_SLT, 3'b010);
        dec(2'b01, F_AND, 3'b110);
        dec(2'b10, F_ADD, 3'b010);
        dec(2'b10, F_SUB, 3'b110);
        dec(2'b10, F_AND, 3'b000);
        dec(2'b10, F_OR,  3'b001);
        dec(2'b10, F_SLT, 3'b111);
        dec(2'b11, F_SLT, 3'b111);
        dec(2'b10, 6'b000000, 3'b010);
        dec(2'b10, F_MULT, 3'b010);
        step();

        // MULT -3 * 7, with en-gating of stall checked while busy
        issue(F_MULT, 32'hFFFF_FFFD, 32'd7, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
        drive(1'b0, 2'b10, F_MFLO, '0, '0);
        #1;
        check("stall_en0", ext(stall), '0);
        en = 1'b1;
        #1;
        check("stall_en1", ext(stall), 1);
        en = 1'b0;
        run_to_idle(n);
        check("busy_len", n, 33);
        check("done_pulse", ext(done), 1);
        step();
        check("done_clear", ext(done), '0);

        mdu_op(F_MULTU, 32'hFFFF_FFFF, 32'd2, {32'd1, 32'hFFFF_FFFE});
        mdu_op(F_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        mdu_op(F_DIVU, 32'd7, 32'd0, {32'd7, 32'hFFFF_FFFF});
        mdu_op(F_DIV, 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFB, 32'hFFFF_FFFF});
        mdu_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});

        for (int i = 0; i < 6; i++) begin
            case (i % 4)
                0:       f = F_MULT;
                1:       f = F_MULTU;
                2:       f = F_DIV;
                default: f = F_DIVU;
            endcase
            x = $urandom;
            y = (i >= 2) ? $urandom_range(1, 1000) : $urandom;
            if (i == 4) y = -y;
            mdu_op(f, x, y, model(f, x, y));
        end

        // MFLO right behind MULT 5 x 6 stalls for the whole operation
        issue(F_MULT, 32'd5, 32'd6, 1'b1, {32'd0, 32'd30});
        drive(1'b1, 2'b10, F_MFLO, '0, '0);
        #1;
        n = 0;
        while (stall === 1'b1 && n < 100) begin step(); n++; end
        check("mflo_stall_len", n, 33);
        check("mflo_result", mf_result, 30);
        step();
        en = 1'b0;

        // An ADD between MULT and MFLO is not stalled
        issue(F_MULT, 32'd3, 32'd4, 1'b1, {32'd0, 32'd12});
        drive(1'b1, 2'b10, F_ADD, '0, '0);
        #1;
        check("add_stall", ext(stall), '0);
        check("add_ctrl", {{(W-3){1'b0}}, alu_ctrl}, 2);
        step();
        drive(1'b1, 2'b10, F_MFLO, '0, '0);
        #1;
        n = 0;
        while (stall === 1'b1 && n < 100) begin step(); n++; end
        check("mflo2_stall_len", n, 32);
        check("mflo2_result", mf_result, 12);
        step();
        en = 1'b0;

        // MTHI / MTLO then MFHI / MFLO while idle
        drive(1'b1, 2'b10, F_MTHI, 32'h1234, '0);
        #1;
        check("mthi_stall", ext(stall), '0);
        step();
        check("mthi_hi", hi, 32'h1234);
        drive(1'b1, 2'b10, F_MFHI, '0, '0);
        #1;
        check("mfhi_stall", ext(stall), '0);
        check("mfhi_result", mf_result, 32'h1234);
        step();
        drive(1'b1, 2'b10, F_MTLO, 32'h5678, '0);
        #1;
        check("mtlo_stall", ext(stall), '0);
        step();
        check("mtlo_lo", lo, 32'h5678);
        drive(1'b1, 2'b10, F_MFLO, '0, '0);
        #1;
        check("mflo_idle", mf_result, 32'h5678);
        step();
        en = 1'b0;

        // Second MULT while busy waits and starts the cycle busy falls
        issue(F_MULT, 32'd2, 32'd3, 1'b1, {32'd0, 32'd6});
        drive(1'b1, 2'b10, F_MULT, 32'd4, 32'd5);
        #1;
        n = 0;
        while (stall === 1'b1 && n < 100) begin step(); n++; end
        check("mult2_stall_len", n, 33);
        check("mult2_busy_low", ext(busy), '0);
        sb.push_back({32'd0, 32'd20});
        step();
        en = 1'b0;
        check("mult2_started", ext(busy), 1);
        run_to_idle(n);
        check("mult2_busy_len", n, 33);
        step();

        // Reset at cycle 10 of a DIV discards it
        issue(F_DIV, 32'd100, 32'd7, 1'b0, '0);
        repeat (9) step();
        check("pre_rst_busy", ext(busy), 1);
        reset = 1'b1;
        drive(1'b0, 2'b10, F_MFHI, '0, '0);
        step();
        reset = 1'b0;
        check("midrst_busy", ext(busy), '0);
        check("midrst_hi", hi, '0);
        check("midrst_lo", lo, '0);
        check("midrst_done", ext(done), '0);
        check("midrst_mf", mf_result, '0);
        check("midrst_stall", ext(stall), '0);
        repeat (40) step();
        mdu_op(F_DIV, 32'd100, 32'd7, {32'd2, 32'd14});

        check("sb_empty", sb.size(), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
